// File: rtl/prog_counter_pkg.sv
// prog_counter_pkg: shared types for the programmable counter.
// Defines the mode encodings (cnt_mode_e) and the one-shot FSM states (cnt_state_e).
// Imported by prog_counter.
package prog_counter_pkg;

  // Mode field encodings; 2'b11 is reserved and behaves as wrap.
  typedef enum logic [1:0] {
    CNT_WRAP    = 2'b00,
    CNT_SAT     = 2'b01,
    CNT_ONESHOT = 2'b10,
    CNT_RSVD    = 2'b11
  } cnt_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } cnt_state_e;

endpackage

// File: rtl/prog_counter_prescaler.sv
// prog_counter_prescaler: divides cnt_en into ticks, one tick every (prescale+1) enabled cycles.
// Ports: clk_i/rst_i (async active-high), en_i, clr_i (sync divider clear), prescale_i, tick_o.
// tick_o is combinational from the divider state and en_i; used only with CNT_PRESCALE_EN.
module prog_counter_prescaler #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  tick_o
);

  logic [PRESCALE_W-1:0] div_q;
  logic [PRESCALE_W-1:0] div_d;

  assign tick_o = en_i && (div_q == prescale_i);

  always_comb begin
    div_d = div_q;
    if (clr_i) begin
      div_d = '0;
    end else if (tick_o) begin
      div_d = '0;
    end else if (en_i) begin
      // A prescale value lowered below the divider lets it roll over modulo 2^PRESCALE_W.
      div_d = div_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/prog_counter.sv
// prog_counter: programmable up/down counter with wrap, saturate and one-shot modes.
// Ports: cnt_clk, cnt_rst (async active-high), cnt_en/clr/load/start controls, cnt_load_val,
//   cnt_dir, cnt_mode, cnt_limit, cnt_prescale (CNT_PRESCALE_EN only); outputs cnt_o, cnt_tc_o, cnt_done_o, cnt_busy_o.
// Macro CNT_PRESCALE_EN adds the tick prescaler; all outputs are registered.
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int WIDTH      = 5,
  parameter int PRESCALE_W = 4
) (
  input  logic                  cnt_clk,
  input  logic                  cnt_rst,
  input  logic                  cnt_en,
  input  logic                  cnt_clr,
  input  logic                  cnt_load,
  input  logic [WIDTH-1:0]      cnt_load_val,
  input  logic                  cnt_dir,
  input  logic [1:0]            cnt_mode,
  input  logic [WIDTH-1:0]      cnt_limit,
  input  logic                  cnt_start,
`ifdef CNT_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] cnt_prescale,
`endif
  output logic [WIDTH-1:0]      cnt_o,
  output logic                  cnt_tc_o,
  output logic                  cnt_done_o,
  output logic                  cnt_busy_o
);

  cnt_mode_e        mode;
  cnt_state_e       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             busy_q, done_q;
  logic             tick;
  logic             oneshot;
  logic             start_eff;
  logic             at_term;
  logic [WIDTH-1:0] stop_val;   // saturate / one-shot end point
  logic [WIDTH-1:0] reload_val; // wrap reload and one-shot start point
  logic [WIDTH-1:0] step_val;

  assign mode      = cnt_mode_e'(cnt_mode);
  assign oneshot   = (mode == CNT_ONESHOT);
  assign start_eff = cnt_start && oneshot;

  // Up uses >= so a lowered limit or a load above it still terminates on the next tick.
  assign at_term    = cnt_dir ? (cnt_q == '0) : (cnt_q >= cnt_limit);
  assign stop_val   = cnt_dir ? '0 : cnt_limit;
  assign reload_val = cnt_dir ? cnt_limit : '0;
  assign step_val   = cnt_dir ? (cnt_q - WIDTH'(1)) : (cnt_q + WIDTH'(1));

`ifdef CNT_PRESCALE_EN
  prog_counter_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk_i      (cnt_clk),
    .rst_i      (cnt_rst),
    .en_i       (cnt_en),
    .clr_i      (cnt_clr | cnt_load | start_eff),
    .prescale_i (cnt_prescale),
    .tick_o     (tick)
  );
`else
  logic [PRESCALE_W-1:0] unused_prescale;
  assign unused_prescale = '0;
  assign tick            = cnt_en;
`endif

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    tc_d    = 1'b0;
    if (cnt_clr) begin
      cnt_d   = '0;
      state_d = ST_IDLE;
    end else if (cnt_load) begin
      cnt_d = cnt_load_val;
    end else if (start_eff) begin
      // Start from IDLE, restart from RUN or DONE all behave the same.
      cnt_d   = reload_val;
      state_d = ST_RUN;
    end else if (tick) begin
      case (mode)
        CNT_SAT: begin
          if (at_term) begin
            cnt_d = stop_val;
            tc_d  = 1'b1;
          end else begin
            cnt_d = step_val;
          end
        end
        CNT_ONESHOT: begin
          if (state_q == ST_RUN) begin
            if (at_term) begin
              cnt_d   = stop_val;
              tc_d    = 1'b1;
              state_d = ST_DONE;
            end else begin
              cnt_d = step_val;
            end
          end
        end
        default: begin
          if (at_term) begin
            cnt_d = reload_val;
            tc_d  = 1'b1;
          end else begin
            cnt_d = step_val;
          end
        end
      endcase
    end
    // The FSM only lives in one-shot mode; any other mode parks it.
    if (!oneshot) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge cnt_clk or posedge cnt_rst) begin
    if (cnt_rst) begin
      cnt_q   <= '0;
      tc_q    <= 1'b0;
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
      state_q <= state_d;
      busy_q  <= (state_d == ST_RUN);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign cnt_o      = cnt_q;
  assign cnt_tc_o   = tc_q;
  assign cnt_busy_o = busy_q;
  assign cnt_done_o = done_q;

endmodule

// File: tb/tb_prog_counter.sv
module tb_prog_counter;

  localparam int W  = 5;
  localparam int PW = 4;

  logic         cnt_clk = 1'b0;
  logic         cnt_rst;
  logic         cnt_en;
  logic         cnt_clr;
  logic         cnt_load;
  logic [W-1:0] cnt_load_val;
  logic         cnt_dir;
  logic [1:0]   cnt_mode;
  logic [W-1:0] cnt_limit;
  logic         cnt_start;
`ifdef CNT_PRESCALE_EN
  logic [PW-1:0] cnt_prescale;
`endif
  logic [W-1:0] cnt_o;
  logic         cnt_tc_o;
  logic         cnt_done_o;
  logic         cnt_busy_o;

  int tests_run    = 0;
  int tests_failed = 0;

  prog_counter #(.WIDTH(W), .PRESCALE_W(PW)) dut (
    .cnt_clk      (cnt_clk),
    .cnt_rst      (cnt_rst),
    .cnt_en       (cnt_en),
    .cnt_clr      (cnt_clr),
    .cnt_load     (cnt_load),
    .cnt_load_val (cnt_load_val),
    .cnt_dir      (cnt_dir),
    .cnt_mode     (cnt_mode),
    .cnt_limit    (cnt_limit),
    .cnt_start    (cnt_start),
`ifdef CNT_PRESCALE_EN
    .cnt_prescale (cnt_prescale),
`endif
    .cnt_o        (cnt_o),
    .cnt_tc_o     (cnt_tc_o),
    .cnt_done_o   (cnt_done_o),
    .cnt_busy_o   (cnt_busy_o)
  );

  always #5 cnt_clk = ~cnt_clk;

  // Advance one rising edge and settle 1ns after it.
  task automatic clk_step();
    @(posedge cnt_clk);
    #1;
  endtask

  task automatic do_reset();
    cnt_en = 0; cnt_clr = 0; cnt_load = 0; cnt_load_val = '0; cnt_dir = 0;
    cnt_mode = 2'b00; cnt_limit = '0; cnt_start = 0;
`ifdef CNT_PRESCALE_EN
    cnt_prescale = '0;
`endif
    cnt_rst = 1;
    repeat (2) @(posedge cnt_clk);
    #1 cnt_rst = 0;
  endtask

  task automatic test_reset();
    logic [7:0] obs;
    do_reset();
    cnt_en = 1; cnt_limit = 5'd9;
    repeat (4) clk_step();
    #2 cnt_rst = 1;
    #1;
    obs = {cnt_o, cnt_tc_o, cnt_busy_o, cnt_done_o};
    tests_run++;
    if (obs !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_async: got %h want 00", obs);
    end
    #1 cnt_rst = 0;
    cnt_en = 0;
    clk_step();
    obs = {cnt_o, cnt_tc_o, cnt_busy_o, cnt_done_o};
    tests_run++;
    if (obs !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_hold: got %h want 00", obs);
    end
  endtask

  // Up wrap, limit 5: 0..5,0 with tc alongside the wrapped 0.
  task automatic test_up_wrap();
    do_reset();
    cnt_limit = 5'd5; cnt_en = 1;
    for (int k = 1; k <= 13; k++) begin
      clk_step();
      tests_run++;
      if (cnt_o !== W'(k % 6) || cnt_tc_o !== (k % 6 == 0)) begin
        tests_failed++;
        $display("FAIL up_wrap k=%0d: got cnt=%0d tc=%b want cnt=%0d tc=%b", k, cnt_o, cnt_tc_o, k % 6, (k % 6 == 0));
      end
    end
  endtask

  // Down saturate from load 3, limit 7: 3,2,1,0 then held at 0 with tc every tick.
  task automatic test_down_sat();
    int exp_c[8]  = '{3, 2, 1, 0, 0, 0, 0, 0};
    bit exp_t[8]  = '{0, 0, 0, 0, 1, 1, 1, 1};
    do_reset();
    cnt_mode = 2'b01; cnt_dir = 1; cnt_limit = 5'd7;
    cnt_load = 1; cnt_load_val = 5'd3;
    clk_step();
    cnt_load = 0; cnt_en = 1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) clk_step();
      tests_run++;
      if (cnt_o !== W'(exp_c[k]) || cnt_tc_o !== exp_t[k]) begin
        tests_failed++;
        $display("FAIL down_sat k=%0d: got cnt=%0d tc=%b want cnt=%0d tc=%b", k, cnt_o, cnt_tc_o, exp_c[k], exp_t[k]);
      end
    end
  endtask

  task automatic test_oneshot();
    int busy_cnt = 0;
    int tc_cnt   = 0;
    do_reset();
    cnt_mode = 2'b10; cnt_limit = 5'd4; cnt_en = 1;
    clk_step();
    tests_run++;
    if (cnt_busy_o !== 1'b0 || cnt_done_o !== 1'b0 || cnt_o !== '0) begin
      tests_failed++;
      $display("FAIL oneshot_idle: got busy=%b done=%b cnt=%0d want 0 0 0", cnt_busy_o, cnt_done_o, cnt_o);
    end
    cnt_start = 1;
    clk_step();
    cnt_start = 0;
    for (int k = 0; k < 10; k++) begin
      if (cnt_busy_o) busy_cnt++;
      if (cnt_tc_o) tc_cnt++;
      clk_step();
    end
    tests_run++;
    if (busy_cnt != 5 || tc_cnt != 1) begin
      tests_failed++;
      $display("FAIL oneshot_run: got busy_cycles=%0d tc_pulses=%0d want 5 1", busy_cnt, tc_cnt);
    end
    tests_run++;
    if (cnt_done_o !== 1'b1 || cnt_busy_o !== 1'b0 || cnt_o !== 5'd4) begin
      tests_failed++;
      $display("FAIL oneshot_done: got done=%b busy=%b cnt=%0d want 1 0 4", cnt_done_o, cnt_busy_o, cnt_o);
    end
    cnt_start = 1;
    clk_step();
    cnt_start = 0;
    tests_run++;
    if (cnt_busy_o !== 1'b1 || cnt_done_o !== 1'b0 || cnt_o !== '0) begin
      tests_failed++;
      $display("FAIL oneshot_restart: got busy=%b done=%b cnt=%0d want 1 0 0", cnt_busy_o, cnt_done_o, cnt_o);
    end
    cnt_mode = 2'b00;
    clk_step();
    tests_run++;
    if (cnt_busy_o !== 1'b0 || cnt_done_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL oneshot_leave: got busy=%b done=%b want 0 0", cnt_busy_o, cnt_done_o);
    end
  endtask

  task automatic test_load_above();
    do_reset();
    cnt_limit = 5'd10;
    cnt_load = 1; cnt_load_val = 5'd20;
    clk_step();
    cnt_load = 0; cnt_en = 1;
    clk_step();
    tests_run++;
    if (cnt_o !== '0 || cnt_tc_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_above: got cnt=%0d tc=%b want 0 1", cnt_o, cnt_tc_o);
    end
    clk_step();
    clk_step();
    cnt_clr = 1; cnt_load = 1; cnt_load_val = 5'd17;
    clk_step();
    cnt_clr = 0; cnt_load = 0;
    tests_run++;
    if (cnt_o !== '0 || cnt_tc_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL clr_over_load: got cnt=%0d tc=%b want 0 0", cnt_o, cnt_tc_o);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] obs;
    do_reset();
    cnt_mode = 2'b10; cnt_limit = 5'd20; cnt_en = 1; cnt_start = 1;
    clk_step();
    cnt_start = 0;
    repeat (3) clk_step();
    #3 cnt_rst = 1;
    #1;
    obs = {cnt_o, cnt_tc_o, cnt_busy_o, cnt_done_o};
    tests_run++;
    if (obs !== 8'h00) begin
      tests_failed++;
      $display("FAIL async_rst_mid_run: got %h want 00", obs);
    end
    #1 cnt_rst = 0;
    repeat (2) clk_step();
    obs = {cnt_o, cnt_tc_o, cnt_busy_o, cnt_done_o};
    tests_run++;
    if (obs !== 8'h00) begin
      tests_failed++;
      $display("FAIL async_rst_idle_after: got %h want 00", obs);
    end
  endtask

`ifdef CNT_PRESCALE_EN
  task automatic test_prescale();
    do_reset();
    cnt_prescale = 4'd2; cnt_limit = 5'd3; cnt_en = 1;
    for (int k = 1; k <= 24; k++) begin
      clk_step();
      tests_run++;
      if (cnt_o !== W'((k / 3) % 4) || cnt_tc_o !== (k % 12 == 0)) begin
        tests_failed++;
        $display("FAIL prescale k=%0d: got cnt=%0d tc=%b want cnt=%0d tc=%b", k, cnt_o, cnt_tc_o, (k / 3) % 4, (k % 12 == 0));
      end
    end
  endtask
`endif

  // Random control traffic against a behavioural model of the counting rules.
  task automatic test_random();
    int m_cnt, m_st, m_ps, lim, modn;
    bit m_tc, up, osh, tk, at;
    logic [7:0] exp_v, obs;
    do_reset();
    m_cnt = 0; m_st = 0; m_ps = 0; m_tc = 0;
    modn = 1 << W;
    for (int i = 0; i < 800; i++) begin
      cnt_clr      = ($urandom_range(31) == 0);
      cnt_load     = ($urandom_range(15) == 0);
      cnt_start    = ($urandom_range(9) == 0);
      cnt_en       = ($urandom_range(3) != 0);
      cnt_load_val = W'($urandom_range(modn - 1));
      if ($urandom_range(19) == 0) cnt_mode = 2'($urandom_range(3));
      if ($urandom_range(19) == 0) cnt_dir = ~cnt_dir;
      if ($urandom_range(24) == 0) cnt_limit = W'($urandom_range(modn - 1));
`ifdef CNT_PRESCALE_EN
      if ($urandom_range(39) == 0) cnt_prescale = PW'($urandom_range(3));
`endif
      up  = (cnt_dir == 1'b0);
      osh = (cnt_mode == 2'b10);
      lim = int'(cnt_limit);
`ifdef CNT_PRESCALE_EN
      tk = 0;
      if (cnt_clr || cnt_load || (cnt_start && osh)) m_ps = 0;
      else if (cnt_en) begin
        if (m_ps == int'(cnt_prescale)) begin tk = 1; m_ps = 0; end
        else m_ps = (m_ps + 1) % (1 << PW);
      end
`else
      tk = cnt_en;
`endif
      at   = up ? (m_cnt >= lim) : (m_cnt == 0);
      m_tc = 0;
      if (cnt_clr) begin
        m_cnt = 0; m_st = 0;
      end else if (cnt_load) begin
        m_cnt = int'(cnt_load_val);
      end else if (cnt_start && osh) begin
        m_cnt = up ? 0 : lim; m_st = 1;
      end else if (tk) begin
        if (cnt_mode == 2'b01) begin
          if (at) begin m_cnt = up ? lim : 0; m_tc = 1; end
          else m_cnt = (m_cnt + (up ? 1 : modn - 1)) % modn;
        end else if (osh) begin
          if (m_st == 1) begin
            if (at) begin m_cnt = up ? lim : 0; m_tc = 1; m_st = 2; end
            else m_cnt = (m_cnt + (up ? 1 : modn - 1)) % modn;
          end
        end else begin
          if (at) begin m_cnt = up ? 0 : lim; m_tc = 1; end
          else m_cnt = (m_cnt + (up ? 1 : modn - 1)) % modn;
        end
      end
      if (!osh) m_st = 0;
      clk_step();
      exp_v = {W'(m_cnt), m_tc, (m_st == 1), (m_st == 2)};
      obs   = {cnt_o, cnt_tc_o, cnt_busy_o, cnt_done_o};
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL random i=%0d: got {cnt,tc,busy,done}=%h want %h", i, obs, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_sat();
    test_oneshot();
    test_load_above();
    test_async_reset();
`ifdef CNT_PRESCALE_EN
    test_prescale();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
